// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters qualified by a pixel strobe,
// with sync/blank decode registered in step with the counters.
module vga_sync_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

  function automatic logic hs_dec(input logic [9:0] xv);
    hs_dec = !((xv >= HS_FIRST) && (xv <= HS_LAST));
  endfunction

  function automatic logic vs_dec(input logic [9:0] yv);
    vs_dec = !((yv >= VS_FIRST) && (yv <= VS_LAST));
  endfunction

  function automatic logic vo_dec(input logic [9:0] xv, input logic [9:0] yv);
    vo_dec = (xv < H_VIS_W) && (yv < V_VIS_W);
  endfunction

  logic [9:0] x_r, y_r, x_next_s, y_next_s;
  logic [7:0] fc_r, fc_next_s;
  logic       hsync_r, vsync_r, video_on_r;
  logic       at_h_last_s, at_v_last_s;

  assign at_h_last_s = (x_r == H_LAST);
  assign at_v_last_s = (y_r == V_LAST);

  // Next counter state; the sync decode is taken from this so it lands with x/y.
  always_comb begin
    x_next_s  = x_r;
    y_next_s  = y_r;
    fc_next_s = fc_r;
    if (pix_en) begin
      if (at_h_last_s) begin
        x_next_s = 10'd0;
        if (at_v_last_s) begin
          y_next_s  = 10'd0;
          fc_next_s = fc_r + 8'd1;
        end else begin
          y_next_s = y_r + 10'd1;
        end
      end else begin
        x_next_s = x_r + 10'd1;
      end
    end else begin
      x_next_s = x_r;
    end
  end

  // Counter and decoded-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      fc_r       <= 8'd0;
      hsync_r    <= hs_dec(10'd0);
      vsync_r    <= vs_dec(10'd0);
      video_on_r <= vo_dec(10'd0, 10'd0);
    end else begin
      x_r        <= x_next_s;
      y_r        <= y_next_s;
      fc_r       <= fc_next_s;
      hsync_r    <= hs_dec(x_next_s);
      vsync_r    <= vs_dec(y_next_s);
      video_on_r <= vo_dec(x_next_s, y_next_s);
    end
  end

  // Pulses mark the strobe that precedes the wrap, so they follow pix_en directly.
  assign line_end    = pix_en & ~reset & at_h_last_s;
  assign frame_start = pix_en & ~reset & at_h_last_s & at_v_last_s;

  assign x           = x_r;
  assign y           = y_r;
  assign frame_count = fc_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign video_on    = video_on_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced 16x10 raster.
module tb_vga_sync_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk, reset, pix_en;
  logic       hsync, vsync, video_on, line_end, frame_start;
  logic [9:0] x, y;
  logic [7:0] frame_count;

  vga_sync_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_end(line_end), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] ex;
    logic [9:0] ey;
    logic [7:0] efc;
    logic       ehs;
    logic       evs;
    logic       evo;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mx = 0, my = 0, mfc = 0;
  int   le_cnt = 0, fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: check pulses against the model, advance model, push and compare.
  task automatic cyc(input logic pe, input logic rst);
    exp_t e, got;
    logic exp_le, exp_fs;
    pix_en = pe;
    reset  = rst;
    #1;
    exp_le = pe && !rst && (mx == HT - 1);
    exp_fs = exp_le && (my == VT - 1);
    chk("line_end", line_end, exp_le);
    chk("frame_start", frame_start, exp_fs);
    if (line_end === 1'b1) le_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (rst) begin
      mx = 0; my = 0; mfc = 0;
    end else if (pe) begin
      if (mx == HT - 1) begin
        mx = 0;
        if (my == VT - 1) begin
          my = 0;
          mfc = (mfc + 1) % 256;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
    e.ex  = 10'(mx);
    e.ey  = 10'(my);
    e.efc = 8'(mfc);
    e.ehs = !(mx >= HV + HF && mx <= HV + HF + HS - 1);
    e.evs = !(my >= VV + VF && my <= VV + VF + VS - 1);
    e.evo = (mx < HV) && (my < VV);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("x", x, got.ex);
    chk("y", y, got.ey);
    chk("frame_count", frame_count, got.efc);
    chk("hsync", hsync, got.ehs);
    chk("vsync", vsync, got.evs);
    chk("video_on", video_on, got.evo);
  endtask

  task automatic strobe4();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    int hs_low, vo_cnt, le0, fs0;
    logic [9:0] hx, hy;
    logic hh, hv, ho;
    logic [7:0] hf;
    reset  = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("reset_hsync", hsync, 1'b1);
    chk("reset_vsync", vsync, 1'b1);
    chk("reset_video_on", video_on, 1'b1);

    // One line at quarter rate.
    hs_low = 0;
    le0 = le_cnt;
    for (int i = 0; i < HT; i++) begin
      if (hsync === 1'b0) hs_low++;
      if (i == HV + HF) chk("hsync_start", hsync, 1'b0);
      strobe4();
    end
    chk("line_x_wrap", x, 10'd0);
    chk("line_y", y, 10'd1);
    chk("hsync_low_strobes", hs_low, HS);
    chk("line_end_once", le_cnt - le0, 1);

    // Finish the first frame, counting visible strobes over the whole frame.
    vo_cnt = HV;
    fs0 = fs_cnt;
    for (int i = HT; i < HT * VT; i++) begin
      if (video_on === 1'b1) vo_cnt++;
      if (x == 10'(HV) && y == 10'd2) chk("video_off_x", video_on, 1'b0);
      if (x == 10'd0 && y == 10'(VV)) chk("video_off_y", video_on, 1'b0);
      strobe4();
    end
    chk("video_on_count", vo_cnt, HV * VV);
    chk("frame_start_once", fs_cnt - fs0, 1);
    chk("frame_count_one", frame_count, 8'd1);

    // Park at x=5,y=3 and starve the strobe.
    while (!(mx == 5 && my == 3)) cyc(1'b1, 1'b0);
    hx = x; hy = y; hh = hsync; hv = vsync; ho = video_on; hf = frame_count;
    le0 = le_cnt; fs0 = fs_cnt;
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0);
    chk("hold_x", x, hx);
    chk("hold_y", y, hy);
    chk("hold_outputs", {hsync, vsync, video_on, frame_count}, {hh, hv, ho, hf});
    chk("hold_no_pulses", (le_cnt - le0) + (fs_cnt - fs0), 0);

    // Reset inside both sync intervals with the strobe active.
    while (!(mx == HV + HF + 1 && my == VV + VF + 1)) cyc(1'b1, 1'b0);
    chk("pre_reset_hsync", hsync, 1'b0);
    chk("pre_reset_vsync", vsync, 1'b0);
    cyc(1'b1, 1'b1);
    chk("mid_reset_x", x, 10'd0);
    chk("mid_reset_y", y, 10'd0);
    chk("mid_reset_fc", frame_count, 8'd0);

    // 256 frames with the strobe tied high.
    fs0 = fs_cnt;
    for (int i = 0; i < 256 * HT * VT; i++) cyc(1'b1, 1'b0);
    chk("fc_wrap", frame_count, 8'd0);
    chk("frame_start_256", fs_cnt - fs0, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
